// File: rtl/data_mem_arbiter.sv
// Data-memory port arbiter: shares one req/gnt/rvalid memory port between the LSU (port 0)
// and instruction fetch (port 1, read-only). Granted transactions are remembered in an
// in-order ID FIFO so each response is routed back to the requester that issued it.
// Optional feature macro: DATA_MEM_ARB_ROUND_ROBIN_EN (alternate winners under contention;
// default build uses fixed LSU-over-IF priority).
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lsu_req_i,
    output logic                  lsu_gnt_o,
    output logic                  lsu_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic                  lsu_we_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    input  logic                  if_req_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    output logic                  spurious_rvalid_o
);

    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic IdLsu = 1'b0;
    localparam logic IdIf  = 1'b1;

    typedef enum logic {
        ArbIdle,
        ArbHold
    } arb_state_e;

    arb_state_e                 state_q, state_d;
    logic                       owner_q, owner_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]            count_q, count_d;

    logic winner;
    logic sel_valid;
    logic sel_id;
    logic full;
    logic grant;
    logic pop;
    logic head_id;

    assign full    = (count_q == CntW'(MAX_OUTSTANDING));
    assign grant   = sel_valid & data_gnt_i;
    assign pop     = data_rvalid_i & (count_q != '0);
    assign head_id = fifo_q[rd_ptr_q];

    // Pointers wrap modulo the FIFO depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    logic last_winner_q, last_winner_d;

    // Under contention the requester that did not win last time gets the port.
    always_comb begin
        if (lsu_req_i && if_req_i) begin
            winner = ~last_winner_q;
        end else if (lsu_req_i) begin
            winner = IdLsu;
        end else begin
            winner = IdIf;
        end
    end

    // Remember who was granted most recently.
    always_comb begin
        last_winner_d = last_winner_q;
        if (grant) begin
            last_winner_d = sel_id;
        end
    end

    // Last-winner register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_winner_q <= IdIf;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end
`else
    // Fixed priority: LSU always beats fetch.
    always_comb begin
        winner = lsu_req_i ? IdLsu : IdIf;
    end
`endif

    // Arbitration FSM: pick a winner in idle, lock it until the memory grants.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        sel_valid = 1'b0;
        sel_id    = owner_q;
        unique case (state_q)
            ArbIdle: begin
                // A full FIFO blocks issue even if a response frees a slot this cycle.
                if (!full && (lsu_req_i || if_req_i)) begin
                    sel_valid = 1'b1;
                    sel_id    = winner;
                    if (!data_gnt_i) begin
                        state_d = ArbHold;
                        owner_d = winner;
                    end
                end
            end
            ArbHold: begin
                sel_valid = 1'b1;
                sel_id    = owner_q;
                if (data_gnt_i) begin
                    state_d = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    // ID FIFO and outstanding counter: push on grant, pop on a matched response.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (grant) begin
            fifo_d[wr_ptr_q] = sel_id;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({grant, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Output muxing; everything is forced low while reset is held.
    always_comb begin
        data_req_o        = 1'b0;
        data_addr_o       = '0;
        data_we_o         = 1'b0;
        data_wdata_o      = '0;
        lsu_gnt_o         = 1'b0;
        if_gnt_o          = 1'b0;
        lsu_rvalid_o      = 1'b0;
        lsu_rdata_o       = '0;
        if_rvalid_o       = 1'b0;
        if_rdata_o        = '0;
        spurious_rvalid_o = 1'b0;
        if (!rst_i) begin
            data_req_o = sel_valid;
            if (sel_valid) begin
                if (sel_id == IdLsu) begin
                    data_addr_o  = lsu_addr_i;
                    data_we_o    = lsu_we_i;
                    data_wdata_o = lsu_wdata_i;
                    lsu_gnt_o    = data_gnt_i;
                end else begin
                    data_addr_o  = if_addr_i;
                    if_gnt_o     = data_gnt_i;
                end
            end
            if (pop) begin
                if (head_id == IdLsu) begin
                    lsu_rvalid_o = 1'b1;
                    lsu_rdata_o  = data_rdata_i;
                end else begin
                    if_rvalid_o  = 1'b1;
                    if_rdata_o   = data_rdata_i;
                end
            end
            spurious_rvalid_o = data_rvalid_i & (count_q == '0);
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ArbIdle;
            owner_q  <= IdIf;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single data-memory port between the load/store unit (LSU, port 0) and instruction fetch (IF, port 1, read-only).
- Sits between both requesters and the memory interface, using the req/gnt/rvalid protocol on all sides.
- Tracks outstanding transactions in an in-order ID FIFO and routes each rvalid/rdata back to the requester that issued it.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
MAX_OUTSTANDING, 2, max granted-but-not-responded transactions (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
lsu_req_i  in  1  LSU request
lsu_gnt_o  out  1  LSU request accepted
lsu_rvalid_o  out  1  LSU response valid
lsu_addr_i  in  ADDR_WIDTH  LSU address
lsu_we_i  in  1  LSU write enable
lsu_wdata_i  in  DATA_WIDTH  LSU write data
lsu_rdata_o  out  DATA_WIDTH  LSU read data
if_req_i  in  1  fetch request
if_gnt_o  out  1  fetch request accepted
if_rvalid_o  out  1  fetch response valid
if_addr_i  in  ADDR_WIDTH  fetch address
if_rdata_o  out  DATA_WIDTH  fetch read data
data_req_o  out  1  memory request
data_gnt_i  in  1  memory grant
data_rvalid_i  in  1  memory response valid
data_addr_o  out  ADDR_WIDTH  memory address
data_we_o  out  1  memory write enable
data_wdata_o  out  DATA_WIDTH  memory write data
data_rdata_i  in  DATA_WIDTH  memory read data
spurious_rvalid_o  out  1  pulse: rvalid received with no outstanding transaction

Behaviour:
- Reset (async, rst_i=1):
  - FSM=ARB_IDLE, FIFO empty, count=0, last_winner=IF.
  - All outputs 0 combinationally while reset is asserted.
  - In-flight transactions are discarded; late rvalids after reset are flagged spurious.
- FSM:
  - ARB_IDLE: if count<MAX_OUTSTANDING and any req, select a winner and drive data_req_o=1 with the winner's addr/we/wdata (IF: we=0, wdata=0) in the same cycle.
    - data_gnt_i=1 the same cycle: stay ARB_IDLE.
    - Otherwise go to ARB_HOLD.
  - ARB_HOLD: the owner is locked; data_req_o=1 with the owner's signals until data_gnt_i; on gnt go to ARB_IDLE.
    - No re-arbitration while holding, even if a higher-priority request arrives.
    - Requesters must hold req/addr/wdata stable until their gnt.
- Grant:
  - Owner's gnt_o = data_gnt_i & data_req_o & owner-selected; the other gnt_o=0.
  - On grant, push the owner ID to the FIFO; count+1.
- Full: count==MAX_OUTSTANDING blocks any new data_req_o in ARB_IDLE, including when a pop happens the same cycle. ARB_HOLD is unreachable when full.
- Response:
  - data_rvalid_i with FIFO non-empty: pop the head; assert that ID's rvalid_o and drive data_rdata_i to that requester's rdata_o combinationally (0-cycle latency); count-1.
  - Non-selected rdata_o=0.
  - data_rvalid_i with FIFO empty: spurious_rvalid_o=1 for that cycle; nothing routed; count unchanged.
- Simultaneous grant and rvalid: push and pop in the same cycle; count unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
- Priority (default): fixed, LSU over IF. last_winner updates on every grant.
- Request path latency: 0 cycles (combinational req/addr mux); gnt is combinational from data_gnt_i.

Optional Feature:
DATA_MEM_ARB_ROUND_ROBIN_EN
- Defined: when both request in ARB_IDLE, the requester that is not last_winner wins; a single requester always wins.
- Undefined: fixed LSU-over-IF priority; last_winner register is unused.

Test Plan:
- Single LSU read, memory grants immediately, rvalid next cycle with rdata=0xDEADBEEF -> lsu_gnt_o=1 in cycle 0; lsu_rvalid_o=1 with lsu_rdata_o=0xDEADBEEF in cycle 1; if_rvalid_o stays 0.
- Both request in the same cycle, default priority -> LSU granted first, IF granted next; rvalids routed LSU then IF. With the macro defined, three back-to-back contention rounds alternate LSU, IF, LSU.
- IF requests, data_gnt_i low for 3 cycles while LSU asserts req in cycle 1 -> data_addr_o stays if_addr_i for all 4 cycles; IF granted in cycle 3; LSU granted after.
- MAX_OUTSTANDING=2: two grants with no rvalid -> data_req_o=0 despite pending req; first rvalid frees a slot; next grant occurs the following cycle, not the same cycle.
- Grant and rvalid in the same cycle at count=1 -> count stays 1; IDs stay in order across pointer wrap over 6 transactions.
- rvalid with empty FIFO -> spurious_rvalid_o=1 for one cycle, no rvalid_o. rst_i asserted mid-transaction -> all outputs 0 immediately and FIFO empty after release.
